// File: rtl/store_buffer_if.sv
// Bundle of core-side store/read requests and memory-side ports for the store buffer.
// The buffer takes the slave view; whoever drives the core and memory side takes the master view.
interface store_buffer_if #(
    parameter int DEPTH = 4
);
    localparam int CW = $clog2(DEPTH) + 1;

    logic          s_valid;
    logic          s_ready;
    logic [29:0]   s_addr;
    logic [31:0]   s_wdata;
    logic [3:0]    s_wstrb;
    logic          r_valid;
    logic          r_ready;
    logic [29:0]   r_addr;
    logic          drain_en;
    logic          flush;
    logic          mem_rready;
    logic [29:0]   mem_raddr;
    logic          mem_wready;
    logic [29:0]   mem_waddr;
    logic [31:0]   mem_wdata;
    logic [3:0]    mem_wstrb;
    logic          empty;
    logic [CW-1:0] count;

    modport slave (
        input  s_valid, s_addr, s_wdata, s_wstrb, r_valid, r_addr, drain_en, flush,
        output s_ready, r_ready, mem_rready, mem_raddr, mem_wready, mem_waddr,
               mem_wdata, mem_wstrb, empty, count
    );

    modport master (
        output s_valid, s_addr, s_wdata, s_wstrb, r_valid, r_addr, drain_en, flush,
        input  s_ready, r_ready, mem_rready, mem_raddr, mem_wready, mem_waddr,
               mem_wdata, mem_wstrb, empty, count
    );
endinterface

// File: rtl/store_buffer.sv
// Merging write buffer between the core store port and the memory write port.
// Reads that hit an undrained store are held off while the buffer drains towards them.
module store_buffer #(
    parameter int DEPTH = 4
) (
    input  logic          clk,
    input  logic          resetb,
    store_buffer_if.slave bus
);
    localparam int CW = $clog2(DEPTH) + 1;
    localparam int PW = $clog2(DEPTH);

    logic [29:0]   addr_q [DEPTH];
    logic [31:0]   data_q [DEPTH];
    logic [3:0]    strb_q [DEPTH];

    logic [PW-1:0] head_q, head_d;
    logic [PW-1:0] tail_q, tail_d;
    logic [PW-1:0] tailIdx;
    logic [CW-1:0] count_q, count_d;
    logic          flushPend_q, flushPend_d;

    logic          nonEmpty;
    logic          full;
    logic          headMatch;
    logic          otherMatch;
    logic          pop;
    logic          hit;
    logic          merge;
    logic          accept;
    logic          push;
    logic          doMerge;

    // The head match is kept apart because a popping head is bypassed by memory.
    always_comb begin
        headMatch  = 1'b0;
        otherMatch = 1'b0;
        for (int k = 0; k < DEPTH; k++) begin
            if ((CW'(k) < count_q) && (addr_q[head_q + PW'(k)] == bus.r_addr)) begin
                if (k == 0) begin
                    headMatch = 1'b1;
                end else begin
                    otherMatch = 1'b1;
                end
            end
        end
    end

    assign nonEmpty = (count_q != '0);
    assign full     = (count_q == CW'(DEPTH));
    assign tailIdx  = tail_q - PW'(1);

    // No memory write may leave the block during a reset cycle.
    assign pop = !resetb && nonEmpty &&
                 (bus.drain_en || flushPend_q || full ||
                  (bus.r_valid && (headMatch || otherMatch)));
    assign hit = otherMatch || (headMatch && !pop);

    assign merge = nonEmpty && (bus.s_addr == addr_q[tailIdx]) &&
                   !((count_q == CW'(1)) && pop) && !flushPend_q;

    assign accept  = bus.s_valid && bus.s_ready;
    assign push    = accept && !merge;
    assign doMerge = accept && merge;

    always_comb begin
        head_d      = pop  ? head_q + PW'(1) : head_q;
        tail_d      = push ? tail_q + PW'(1) : tail_q;
        count_d     = count_q + CW'(push) - CW'(pop);
        flushPend_d = (flushPend_q || (bus.flush && nonEmpty)) && (count_d != '0);
    end

    always_ff @(posedge clk) begin
        if (resetb) begin
            head_q      <= '0;
            tail_q      <= '0;
            count_q     <= '0;
            flushPend_q <= 1'b0;
        end else begin
            head_q      <= head_d;
            tail_q      <= tail_d;
            count_q     <= count_d;
            flushPend_q <= flushPend_d;
        end
    end

    // Entry storage carries no reset; only entries below count are ever observed.
    always_ff @(posedge clk) begin
        if (push) begin
            addr_q[tail_q] <= bus.s_addr;
            data_q[tail_q] <= bus.s_wdata;
            strb_q[tail_q] <= bus.s_wstrb;
        end else if (doMerge) begin
            for (int b = 0; b < 4; b++) begin
                if (bus.s_wstrb[b]) begin
                    data_q[tailIdx][8*b +: 8] <= bus.s_wdata[8*b +: 8];
                end
            end
            strb_q[tailIdx] <= strb_q[tailIdx] | bus.s_wstrb;
        end
    end

    assign bus.s_ready    = !flushPend_q && (!full || merge);
    assign bus.r_ready    = !hit;
    assign bus.mem_rready = bus.r_valid && !hit;
    assign bus.mem_raddr  = bus.r_addr;
    assign bus.mem_wready = pop;
    assign bus.mem_waddr  = addr_q[head_q];
    assign bus.mem_wdata  = data_q[head_q];
    assign bus.mem_wstrb  = strb_q[head_q];
    assign bus.empty      = !nonEmpty;
    assign bus.count      = count_q;
endmodule

// File: tb/tb_store_buffer.sv
// Directed bench for store_buffer: reset, fill/backpressure, merge, read hazard,
// flush and mid-operation reset, with hand-computed expectations.
module tb_store_buffer;
    logic clk;
    logic resetb;
    int   total;
    int   bad;

    store_buffer_if #(.DEPTH(4)) bus ();

    store_buffer #(.DEPTH(4)) dut (
        .clk    (clk),
        .resetb (resetb),
        .bus    (bus)
    );

    // Free-running clock, rising edges at 5, 15, 25, ...
    initial begin
        clk = 1'b0;
        forever #5 clk = ~clk;
    end

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic applyStimulus(input logic v, input logic [29:0] a,
                                 input logic [31:0] d, input logic [3:0] s);
        bus.s_valid = v;
        bus.s_addr  = a;
        bus.s_wdata = d;
        bus.s_wstrb = s;
        #1;
    endtask

    task automatic checkOutput(input string tag, input logic [31:0] observed,
                               input logic [31:0] expected);
        total++;
        assert (observed === expected)
        else begin
            bad++;
            $error("[TB] FAIL %s observed=%0h expected=%0h", tag, observed, expected);
        end
    endtask

    initial begin
        total        = 0;
        bad          = 0;
        resetb       = 1'b1;
        bus.s_valid  = 1'b0;
        bus.s_addr   = '0;
        bus.s_wdata  = '0;
        bus.s_wstrb  = '0;
        bus.r_valid  = 1'b0;
        bus.r_addr   = '0;
        bus.drain_en = 1'b0;
        bus.flush    = 1'b0;

        // Reset held for two cycles.
        tick();
        tick();
        checkOutput("rst_count", 32'(bus.count), 32'd0);
        checkOutput("rst_empty", 32'(bus.empty), 32'd1);
        checkOutput("rst_s_ready", 32'(bus.s_ready), 32'd1);
        checkOutput("rst_r_ready", 32'(bus.r_ready), 32'd1);
        checkOutput("rst_mem_wready", 32'(bus.mem_wready), 32'd0);
        resetb = 1'b0;

        // Fill four entries with draining disabled.
        for (int i = 0; i < 4; i++) begin
            applyStimulus(1'b1, 30'h10 + 30'(i), 32'h100 + 32'(i), 4'hF);
            if (i == 0) checkOutput("first_no_early_write", 32'(bus.mem_wready), 32'd0);
            tick();
        end
        applyStimulus(1'b0, 30'h0, 32'h0, 4'h0);
        checkOutput("fill_count", 32'(bus.count), 32'd4);
        checkOutput("fill_empty", 32'(bus.empty), 32'd0);

        // Fifth store while full: backpressure plus forced pop of the oldest entry.
        applyStimulus(1'b1, 30'h14, 32'h104, 4'hF);
        checkOutput("full_s_ready", 32'(bus.s_ready), 32'd0);
        checkOutput("full_pop", 32'(bus.mem_wready), 32'd1);
        checkOutput("full_pop_addr", 32'(bus.mem_waddr), 32'h10);
        checkOutput("full_pop_data", 32'(bus.mem_wdata), 32'h100);
        tick();
        checkOutput("after_pop_count", 32'(bus.count), 32'd3);
        checkOutput("after_pop_s_ready", 32'(bus.s_ready), 32'd1);
        checkOutput("after_pop_no_write", 32'(bus.mem_wready), 32'd0);
        tick();
        applyStimulus(1'b0, 30'h0, 32'h0, 4'h0);
        checkOutput("refill_count", 32'(bus.count), 32'd4);

        // Drain everything; order must wrap through the circular storage.
        bus.drain_en = 1'b1;
        for (int i = 0; i < 4; i++) begin
            #1;
            checkOutput("drain_wready", 32'(bus.mem_wready), 32'd1);
            checkOutput("drain_addr", 32'(bus.mem_waddr), 32'h11 + 32'(i));
            checkOutput("drain_data", 32'(bus.mem_wdata), 32'h101 + 32'(i));
            tick();
        end
        bus.drain_en = 1'b0;
        #1;
        checkOutput("drained_empty", 32'(bus.empty), 32'd1);
        checkOutput("drained_count", 32'(bus.count), 32'd0);

        // Two stores to the same word merge into one entry.
        applyStimulus(1'b1, 30'h20, 32'h000000AA, 4'b0001);
        tick();
        applyStimulus(1'b1, 30'h20, 32'h0000BB00, 4'b0010);
        checkOutput("merge_s_ready", 32'(bus.s_ready), 32'd1);
        tick();
        applyStimulus(1'b0, 30'h0, 32'h0, 4'h0);
        checkOutput("merge_count", 32'(bus.count), 32'd1);
        checkOutput("merge_no_write", 32'(bus.mem_wready), 32'd0);
        bus.drain_en = 1'b1;
        #1;
        checkOutput("merge_wready", 32'(bus.mem_wready), 32'd1);
        checkOutput("merge_waddr", 32'(bus.mem_waddr), 32'h20);
        checkOutput("merge_wdata", 32'(bus.mem_wdata), 32'h0000BBAA);
        checkOutput("merge_wstrb", 32'(bus.mem_wstrb), 32'b0011);
        tick();
        bus.drain_en = 1'b0;
        #1;
        checkOutput("merge_drained", 32'(bus.count), 32'd0);

        // Read hazard on the second of two buffered stores.
        applyStimulus(1'b1, 30'h30, 32'h300, 4'hF);
        tick();
        applyStimulus(1'b1, 30'h31, 32'h301, 4'hF);
        tick();
        applyStimulus(1'b0, 30'h0, 32'h0, 4'h0);
        bus.r_valid = 1'b1;
        bus.r_addr  = 30'h31;
        #1;
        checkOutput("haz_r_ready0", 32'(bus.r_ready), 32'd0);
        checkOutput("haz_mem_rready0", 32'(bus.mem_rready), 32'd0);
        checkOutput("haz_pop0", 32'(bus.mem_wready), 32'd1);
        checkOutput("haz_pop0_addr", 32'(bus.mem_waddr), 32'h30);
        tick();
        checkOutput("haz_r_ready1", 32'(bus.r_ready), 32'd1);
        checkOutput("haz_mem_rready1", 32'(bus.mem_rready), 32'd1);
        checkOutput("haz_mem_raddr1", 32'(bus.mem_raddr), 32'h31);
        checkOutput("haz_pop1", 32'(bus.mem_wready), 32'd1);
        checkOutput("haz_pop1_addr", 32'(bus.mem_waddr), 32'h31);
        tick();
        bus.r_valid = 1'b0;
        #1;
        checkOutput("haz_empty", 32'(bus.empty), 32'd1);

        // Flush pulse drains three entries in order and blocks new stores.
        for (int i = 0; i < 3; i++) begin
            applyStimulus(1'b1, 30'h40 + 30'(i), 32'h400 + 32'(i), 4'hF);
            tick();
        end
        applyStimulus(1'b0, 30'h0, 32'h0, 4'h0);
        bus.flush = 1'b1;
        #1;
        checkOutput("flush_req_no_write", 32'(bus.mem_wready), 32'd0);
        tick();
        bus.flush = 1'b0;
        applyStimulus(1'b1, 30'h50, 32'h500, 4'hF);
        for (int i = 0; i < 3; i++) begin
            checkOutput("flush_wready", 32'(bus.mem_wready), 32'd1);
            checkOutput("flush_addr", 32'(bus.mem_waddr), 32'h40 + 32'(i));
            checkOutput("flush_s_ready", 32'(bus.s_ready), 32'd0);
            if (i == 2) bus.s_valid = 1'b0;
            tick();
        end
        checkOutput("flush_empty", 32'(bus.empty), 32'd1);
        checkOutput("flush_done_wready", 32'(bus.mem_wready), 32'd0);
        checkOutput("flush_done_s_ready", 32'(bus.s_ready), 32'd1);

        // Reset with two entries buffered and drain requested.
        applyStimulus(1'b1, 30'h60, 32'h600, 4'hF);
        tick();
        applyStimulus(1'b1, 30'h61, 32'h601, 4'hF);
        tick();
        applyStimulus(1'b0, 30'h0, 32'h0, 4'h0);
        checkOutput("pre_rst_count", 32'(bus.count), 32'd2);
        bus.drain_en = 1'b1;
        resetb       = 1'b1;
        #1;
        checkOutput("rst_cycle_no_write", 32'(bus.mem_wready), 32'd0);
        tick();
        resetb       = 1'b0;
        bus.drain_en = 1'b0;
        #1;
        checkOutput("midrst_count", 32'(bus.count), 32'd0);
        checkOutput("midrst_empty", 32'(bus.empty), 32'd1);
        checkOutput("midrst_no_write", 32'(bus.mem_wready), 32'd0);

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end
endmodule

// File: doc/store_buffer.md
Name: store_buffer

Overview:
- Write buffer between the core's data-store port and the write port of the two-port memory model.
- Queues word-aligned byte-strobed stores and merges back-to-back stores to the same word.
- Drains to memory opportunistically or on demand.
- Gates the core's read requests: a read is stalled while it hits an undrained buffered store. Read data and rresp return directly from memory and do not pass through this block.

Parameters:
DEPTH, 4, number of buffer entries; power of 2, at least 2
CW, $clog2(DEPTH)+1, width of the occupancy count (derived localparam)

Ports:
clk  input  1  clock
resetb  input  1  reset; synchronous, active-high (asserted = 1)
s_valid  input  1  store request
s_ready  output  1  store accepted when s_valid && s_ready
s_addr  input  30  store word address [31:2]
s_wdata  input  32  store data
s_wstrb  input  4  store byte strobes
r_valid  input  1  read request from core
r_ready  output  1  read may issue this cycle
r_addr  input  30  read word address [31:2]
drain_en  input  1  permission to drain one entry this cycle
flush  input  1  request full drain
mem_rready  output  1  memory read strobe
mem_raddr  output  30  memory read word address
mem_wready  output  1  memory write strobe
mem_waddr  output  30  memory write word address
mem_wdata  output  32  memory write data
mem_wstrb  output  4  memory write strobes
empty  output  1  buffer holds no entries
count  output  CW  number of valid entries

Behaviour:
- State: circular FIFO of {addr, data, strb}, head/tail pointers, count, flush_pend. Storage array is not reset.
- Reset: count=0, pointers=0, flush_pend=0.
  - Resulting outputs: empty=1, count=0, mem_wready=0, mem_rready=0, s_ready=1, r_ready=1.
  - Reset mid-operation discards all buffered stores; no memory write is issued in the reset cycle.
- hit: any valid entry has addr==r_addr. The head entry is excluded when pop=1 that cycle, because memory bypasses a same-cycle write to the same address.
- pop = (count!=0) && (drain_en || flush_pend || count==DEPTH || (r_valid && hit)).
- mem_wready=pop. mem_waddr/mem_wdata/mem_wstrb carry the head entry; the memory write port accepts every cycle. When pop=0, mem_w* values are don't-care.
- merge = (count!=0) && s_addr==tail_addr && !(count==1 && pop) && !flush_pend.
  - tail_addr is the address of the newest entry.
  - On merge, strobed bytes overwrite the tail entry's data and the tail strb ORs in s_wstrb. count is unchanged.
- s_ready = !flush_pend && (count<DEPTH || merge).
  - s_ready may depend on s_addr but never on s_valid.
  - When full with no merge, s_ready=0 even if pop=1 the same cycle (no full-bypass).
- Push (accept without merge): write the tail and advance it.
  - count_next = count + push - pop. Pointers wrap modulo DEPTH.
  - Simultaneous push and pop keeps count unchanged.
- Latency: a store accepted in cycle N appears on mem_wready no earlier than N+1.
- Reads:
  - r_ready = !hit; mem_rready = r_valid && r_ready; mem_raddr = r_addr, combinational.
  - A hazarded read forces pop each cycle and stalls at most count cycles.
- Flush:
  - flush=1 with count!=0 sets flush_pend.
  - flush_pend clears in the cycle count_next==0.
  - flush with count==0 has no effect.
- empty = (count==0), from registered state.

Test Plan:
- Reset: drive resetb=1 for 2 cycles → count=0, empty=1, s_ready=1, r_ready=1, mem_wready=0.
- Fill/backpressure, DEPTH=4, drain_en=0: issue stores to words 0x10, 0x11, 0x12, 0x13 → count=4.
  - Fifth store to 0x14: s_ready=0, forced pop of 0x10 that cycle.
  - Store 0x14 accepted next cycle → count=4.
- Merge: store 0x20 data 0x000000AA strb 0001, then 0x20 data 0x0000BB00 strb 0010.
  - count=1; on drain, mem_wdata=0x0000BBAA, mem_wstrb=0011.
- Read hazard: buffer holds 0x30, 0x31, drain_en=0; r_valid with r_addr=0x31.
  - r_ready=0 for 1 cycle while 0x30 pops.
  - Next cycle 0x31 pops, r_ready=1, mem_rready=1 the same cycle.
- Flush: 3 entries, drain_en=0, pulse flush 1 cycle.
  - mem_wready=1 for 3 consecutive cycles in FIFO order, s_ready=0 throughout, then empty=1.
- Mid-operation reset: 2 entries buffered, assert resetb for 1 cycle → no mem_wready in the reset cycle, then count=0, empty=1.
